// File: rtl/display_pkg.sv
// Shared widths and scan-state encoding for the 4-digit multiplexed display controller.
package display_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = 2;
  localparam int NIB_W      = 4;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;
endpackage

// File: rtl/scan_timer.sv
// Free-running slot counter; strobes the last blanking cycle and the last cycle of a slot.
module scan_timer #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  output logic blank_done,
  output logic slot_done
);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    slot_done  = (cnt_q == SLOT_LAST);
    blank_done = (cnt_q == BLANK_LAST);
    cnt_d      = slot_done ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit scan controller: per-slot blanking, frame-atomic input snapshot,
// per-digit decimal point and blink.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           value,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic                  disp_on,
  output logic [NIB_W-1:0]      digit,
  output logic [SEL_W-1:0]      sel,
  output logic                  dec,
  output logic                  en,
  output logic                  frame_start
);
  localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

  scan_state_e state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [FR_W-1:0]  frame_q, frame_d;
  logic             blink_phase_q, blink_phase_d;
  logic             first_q;
  logic             blank_done, slot_done, snap;

  logic [NUM_DIGITS-1:0][NIB_W-1:0] sh_val_q;
  logic [NUM_DIGITS-1:0]            sh_dp_q, sh_blink_q;
  logic                             sh_phase_q;

  scan_timer #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .blank_done (blank_done),
    .slot_done  (slot_done)
  );

  // first_q marks the opening cycle of every BLANK period
  assign snap = first_q && (sel_q == '0);

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    frame_d       = frame_q;
    blink_phase_d = blink_phase_q;
    case (state_q)
      BLANK: if (blank_done) state_d = SHOW;
      SHOW: if (slot_done) begin
        state_d = BLANK;
        sel_d   = sel_q + 1'b1;
      end
      default: state_d = BLANK;
    endcase
    if (snap) begin
      if (frame_q == FR_LAST) begin
        frame_d       = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BLANK;
      sel_q         <= '0;
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
      first_q       <= 1'b1;
      sh_val_q      <= '0;
      sh_dp_q       <= '0;
      sh_blink_q    <= '0;
      sh_phase_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      frame_q       <= frame_d;
      blink_phase_q <= blink_phase_d;
      first_q       <= slot_done;
      if (snap) begin
        sh_val_q   <= value;
        sh_dp_q    <= dp_mask;
        sh_blink_q <= blink_mask;
        // phase is frozen with the snapshot so an entire frame blinks as one
        sh_phase_q <= blink_phase_q;
      end
    end
  end

  always_comb begin
    digit       = sh_val_q[sel_q];
    sel         = sel_q;
    dec         = ~sh_dp_q[sel_q];
    en          = (state_q == SHOW) && disp_on && !(sh_phase_q && sh_blink_q[sel_q]);
    frame_start = snap;
    if (rst) begin
      digit       = '0;
      sel         = '0;
      dec         = 1'b1;
      en          = 1'b0;
      frame_start = 1'b0;
    end
  end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz).
REQ-002 SHALL provide parameter BLANK_CYC, default 16, blanking cycles at the start of each slot; legal range 1 <= BLANK_CYC < SCAN_DIV.
REQ-003 SHALL provide parameter BLINK_FRAMES, default 125, full 4-digit frames per blink half-period; minimum 1.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 value  input  16  four hex nibbles; nibble i = value[4i+3:4i] shown on digit i.
REQ-007 dp_mask  input  4  bit i=1 lights decimal point of digit i.
REQ-008 blink_mask  input  4  bit i=1 makes digit i blink.
REQ-009 disp_on  input  1  0 blanks the whole display.
REQ-010 digit  output  4  nibble for the segment decoder.
REQ-011 sel  output  2  active digit index, drives the decoder's anode select.
REQ-012 dec  output  1  decimal-point line, active-low (0 = lit).
REQ-013 en  output  1  decoder enable, active-high; 0 turns all anodes off.
REQ-014 frame_start  output  1  one-cycle pulse marking input snapshot.

Function
REQ-015 SHALL implement FSM {BLANK, SHOW}: BLANK lasts exactly BLANK_CYC cycles, then SHOW lasts exactly SCAN_DIV-BLANK_CYC cycles, then BLANK with sel incremented.
REQ-016 Slot period SHALL be exactly SCAN_DIV cycles; frame period SHALL be exactly 4*SCAN_DIV cycles.
REQ-017 sel SHALL wrap 3 -> 0; sel SHALL change only on the SHOW->BLANK transition.
REQ-018 On the first cycle of BLANK with sel=0, value/dp_mask/blink_mask SHALL be captured into shadow registers and frame_start SHALL be 1 for that cycle only.
REQ-019 Input changes at any other cycle SHALL NOT affect digit/dec/en before the next snapshot (no mid-frame tearing).
REQ-020 digit SHALL equal shadow nibble[sel] and dec SHALL equal ~shadow_dp[sel] in both states.
REQ-021 en SHALL be 0 throughout BLANK.
REQ-022 en in SHOW SHALL equal disp_on AND NOT (blink_phase AND shadow_blink[sel]); disp_on is sampled live, not snapshotted.
REQ-023 Frame counter SHALL increment on each snapshot; when it reaches BLINK_FRAMES it SHALL clear to 0 and toggle blink_phase in the same cycle.
REQ-024 disp_on=0 SHALL NOT stop or reset the FSM, slot counter, sel, frame counter or blink_phase.
REQ-025 Outputs SHALL be driven from registered state and shadow registers only; no combinational path from value/dp_mask/blink_mask to outputs. disp_on reaches en combinationally by design (REQ-022).

Reset
REQ-026 During rst=1: state=BLANK, slot counter=0, sel=0, frame counter=0, blink_phase=0, shadow regs=0.
REQ-027 Outputs during rst=1: en=0, digit=0, sel=0, dec=1, frame_start=0.
REQ-028 The first cycle after rst falls SHALL be a snapshot cycle (frame_start=1).
REQ-029 rst asserted mid-slot SHALL abandon the slot with no partial-slot completion.

Structure
REQ-030 Shared package display_pkg SHALL hold NUM_DIGITS=4, SEL_W=2, NIB_W=4 and the state enum {BLANK, SHOW}.
REQ-031 One sub-module, scan_timer, SHALL hold the slot counter and emit blank_done/slot_done strobes; FSM, shadow regs and blink logic SHALL stay in display_scan_ctrl.

Verification (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-032 Release rst, value=16'h1234, dp_mask=0 -> frame_start at cycle 0; slots show (sel,digit)=(0,4),(1,3),(2,2),(3,1); en=0 for 2 cycles then 1 for 6 cycles per slot; frame_start every 32 cycles.
REQ-033 Change value to 16'hABCD at cycle 10 -> cycles 10-31 still show 1234 nibbles; snapshot at cycle 32 -> digit=D at sel=0.
REQ-034 dp_mask=4'b0100 -> dec=0 only while sel=2; dec=1 for all other slots, including during BLANK.
REQ-035 blink_mask=4'b0001 -> sel=0 en pattern per frame: on,on,off,off,on,... (toggle every 2 frames); digits 1-3 unaffected.
REQ-036 disp_on=0 for cycles 40-60 -> en=0 throughout, sel/frame_start timing unchanged; en resumes in SHOW at cycle 61.
REQ-037 Assert rst at cycle 13 (mid SHOW, sel=1) for 1 cycle -> cycle 13 outputs equal REQ-027 values; frame_start=1 at cycle 14; sel=0; full 32-cycle frame follows.
